top: RTL and testbench

TOP -- requirements
Module: top

---
 rtl/top_pkg.sv | 16 +
 rtl/top_blink_prescaler.sv | 28 ++
 rtl/top.sv | 70 +++++++
 tb/tb_top.sv | 138 +++++++++++++
 4 files changed

// File: rtl/top_pkg.sv
// Shared constants and the half-period calculation for the LED blinker.
package top_pkg;

  localparam int DEFAULT_CLK_FREQ_HZ = 50_000_000;
  localparam int DEFAULT_BLINK_HZ    = 1;
  localparam int PWM_WIDTH           = 8;

  // Clock edges per half blink period, integer-truncated; 0 flags an unusable rate.
  function automatic int half_period_cycles(input int clk_freq_hz, input int blink_hz);
    if (blink_hz <= 0) begin
      return 0;
    end
    return clk_freq_hz / (2 * blink_hz);
  endfunction

endpackage

// File: rtl/top_blink_prescaler.sv
// Prescaler for the blinker: counts 0..HALF_PERIOD_CYCLES-1 and flags the wrap cycle.
module blink_prescaler #(
  parameter int HALF_PERIOD_CYCLES = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = (HALF_PERIOD_CYCLES < 1) ? 1 : $clog2(HALF_PERIOD_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF_PERIOD_CYCLES - 1);

  logic [CNT_W-1:0] cnt_reg;

  // Tick is high for the cycle whose closing edge wraps the counter back to 0.
  assign tick = (cnt_reg == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/top.sv
// LED blinker top: prescaled 50% square wave on a registered led pin.
// Define TOP_PWM_EN to dim the on-phase with an 8-bit PWM of duty PWM_DUTY/256.
module top
  import top_pkg::*;
#(
  parameter int CLK_FREQ_HZ    = DEFAULT_CLK_FREQ_HZ,
  parameter int BLINK_HZ       = DEFAULT_BLINK_HZ,
  parameter int LED_ACTIVE_LOW = 0,
  parameter int PWM_DUTY       = 64
) (
  input  logic clk,
  input  logic rst,
  output logic led
);

  localparam int HALF_PERIOD_CYCLES = half_period_cycles(CLK_FREQ_HZ, BLINK_HZ);
  localparam logic LED_POL = (LED_ACTIVE_LOW != 0);

  if (BLINK_HZ == 0 || HALF_PERIOD_CYCLES < 1) begin : g_bad_rate
    $error("top: BLINK_HZ must be nonzero and CLK_FREQ_HZ/(2*BLINK_HZ) at least 1");
  end
  if (PWM_DUTY < 0 || PWM_DUTY > 255) begin : g_bad_duty
    $error("top: PWM_DUTY must be in 0..255");
  end

  logic tick;
  logic blink_reg;
  logic blink_next;
  logic led_on_next;

  blink_prescaler #(
    .HALF_PERIOD_CYCLES(HALF_PERIOD_CYCLES)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  assign blink_next = blink_reg ^ tick;

`ifdef TOP_PWM_EN
  logic [PWM_WIDTH-1:0] pwm_cnt_reg;
  logic [PWM_WIDTH-1:0] pwm_cnt_next;

  assign pwm_cnt_next = pwm_cnt_reg + 1'b1;
  assign led_on_next  = blink_next & (pwm_cnt_next < PWM_WIDTH'(PWM_DUTY));

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_reg <= '0;
    end else begin
      pwm_cnt_reg <= pwm_cnt_next;
    end
  end
`else
  assign led_on_next = blink_next;
`endif

  // led is loaded from next-state values so the pin changes on the toggle edge itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_reg <= 1'b0;
      led       <= LED_POL;
    end else begin
      blink_reg <= blink_next;
      led       <= led_on_next ^ LED_POL;
    end
  end

endmodule

// File: tb/tb_top.sv
// Directed bench for top: HALF=4 (both polarities), HALF=1, and a HALF=1024 PWM run.
module tb_top;

  logic clk;
  logic rst;
  logic led_a;
  logic led_b;
  logic led_c;
  logic led_d;

  int n_checks;
  int n_fail;

  typedef struct {
    logic rst;
    logic exp_a;
    logic exp_b;
    logic exp_c;
  } vec_t;

  vec_t vecs[$];

  initial clk = 1'b0;
  always #20 clk = ~clk;

  top #(.CLK_FREQ_HZ(8), .BLINK_HZ(1), .LED_ACTIVE_LOW(0)) dut_a (
    .clk(clk), .rst(rst), .led(led_a));
  top #(.CLK_FREQ_HZ(8), .BLINK_HZ(1), .LED_ACTIVE_LOW(1)) dut_b (
    .clk(clk), .rst(rst), .led(led_b));
  top #(.CLK_FREQ_HZ(2), .BLINK_HZ(1), .LED_ACTIVE_LOW(0)) dut_c (
    .clk(clk), .rst(rst), .led(led_c));
  top #(.CLK_FREQ_HZ(2048), .BLINK_HZ(1), .LED_ACTIVE_LOW(0), .PWM_DUTY(64)) dut_d (
    .clk(clk), .rst(rst), .led(led_d));

  task automatic add(input logic r, input logic a, input logic c);
    vec_t v;
    v.rst   = r;
    v.exp_a = a;
    v.exp_b = ~a;
    v.exp_c = c;
    vecs.push_back(v);
  endtask

  task automatic step(input logic r);
    rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string name, input int idx, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: led=%b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: high count=%0d expected %0d", name, act, exp);
    end else begin
      $display("pwm %s: high count=%0d", name, act);
    end
  endtask

  int on_exp;
  int highs;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;

    // Reset held for three edges
    for (int i = 0; i < 3; i++) add(1, 0, 0);
    // Release: HALF=4 sequence 0,0,0,1,1,1,1,0,0,0,0; HALF=1 toggles every edge
    add(0, 0, 1); add(0, 0, 0); add(0, 0, 1); add(0, 1, 0);
    add(0, 1, 1); add(0, 1, 0); add(0, 1, 1); add(0, 0, 0);
    add(0, 0, 1); add(0, 0, 0); add(0, 0, 1);
    // Run until HALF=4 counter is 2 with state 1
    add(0, 1, 0); add(0, 1, 1); add(0, 1, 0);
    // One-edge reset mid-count, then next toggle 4 edges after release
    add(1, 0, 0);
    add(0, 0, 1); add(0, 0, 0); add(0, 0, 1); add(0, 1, 0); add(0, 1, 1);
    // Reset on the wrap edge must beat the tick
    add(0, 1, 0); add(0, 1, 1);
    add(1, 0, 0);
    add(0, 0, 1);

    foreach (vecs[i]) begin
      step(vecs[i].rst);
      $display("vec %0d rst=%b led_a=%b led_b=%b led_c=%b", i, vecs[i].rst, led_a, led_b, led_c);
      check_bit("half4_led", i, led_a, vecs[i].exp_a);
      check_bit("half4_active_low", i, led_b, vecs[i].exp_b);
      check_bit("half1_led", i, led_c, vecs[i].exp_c);
    end

    // PWM / long-period run on dut_d (HALF=1024)
    step(1);
    step(1);
    check_bit("half1024_reset", 0, led_d, 1'b0);

`ifdef TOP_PWM_EN
    on_exp = 64;
`else
    on_exp = 256;
`endif

    highs = 0;
    for (int k = 1; k <= 1023; k++) begin
      step(0);
      highs += int'(led_d);
    end
    check_int("off_phase_1", highs, 0);

    for (int w = 0; w < 4; w++) begin
      highs = 0;
      for (int k = 0; k < 256; k++) begin
        step(0);
        highs += int'(led_d);
      end
      check_int($sformatf("on_window_%0d", w), highs, on_exp);
    end

    highs = 0;
    for (int k = 0; k < 256; k++) begin
      step(0);
      highs += int'(led_d);
    end
    check_int("off_phase_2", highs, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
